// File: rtl/ifu.sv
// Instruction fetch unit: one outstanding word fetch, presents {pc, inst} to decode.
// Optional misaligned-redirect check is enabled with IFU_MISALIGN_CHK_EN.
module ifu #(
    parameter int                    ADDR_WIDTH = 32,
    parameter int                    INST_WIDTH = 32,
    parameter logic [ADDR_WIDTH-1:0] RESET_PC   = 'h8000_0000
) (
    input  logic                  i_clk,
    input  logic                  i_rst_n,
    output logic                  o_mem_req_valid,
    input  logic                  i_mem_req_ready,
    output logic [ADDR_WIDTH-1:0] o_mem_req_addr,
    input  logic                  i_mem_rsp_valid,
    input  logic [INST_WIDTH-1:0] i_mem_rsp_data,
    input  logic                  i_jmp_en,
    input  logic [ADDR_WIDTH-1:0] i_jmp_pc,
    output logic                  o_valid,
    input  logic                  i_ready,
    output logic [ADDR_WIDTH-1:0] o_pc,
    output logic [INST_WIDTH-1:0] o_inst,
    output logic                  o_exc_misalign
);

    typedef enum logic [1:0] {IDLE, REQ, WAIT, HOLD} state_e;

    state_e                state_q, state_d;
    logic [ADDR_WIDTH-1:0] pc_q, pc_d;
    logic                  kill_q, kill_d;
    logic [ADDR_WIDTH-1:0] opc_q;
    logic [INST_WIDTH-1:0] inst_q;
    logic                  exc_q, exc_d;
    logic                  cap;
    logic                  jmp_go;
    logic [ADDR_WIDTH-1:0] jmp_tgt;

`ifdef IFU_MISALIGN_CHK_EN
    assign jmp_go  = i_jmp_en && (i_jmp_pc[1:0] == 2'b00);
    assign jmp_tgt = i_jmp_pc;
    assign exc_d   = i_jmp_en && (i_jmp_pc[1:0] != 2'b00);
`else
    logic unused_jmp_lsb;
    assign unused_jmp_lsb = ^i_jmp_pc[1:0];
    assign jmp_go  = i_jmp_en;
    assign jmp_tgt = {i_jmp_pc[ADDR_WIDTH-1:2], 2'b00};
    assign exc_d   = 1'b0;
`endif

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q <= IDLE;
            pc_q    <= RESET_PC;
            kill_q  <= 1'b0;
            opc_q   <= '0;
            inst_q  <= '0;
            exc_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            kill_q  <= kill_d;
            exc_q   <= exc_d;
            if (cap) begin
                opc_q  <= pc_q;
                inst_q <= i_mem_rsp_data;
            end
        end
    end

    // Redirect overrides the sequential pc update in every state; a redirect while a
    // request is in flight marks its response as stale.
    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        kill_d  = kill_q;
        cap     = 1'b0;
        case (state_q)
            IDLE: state_d = REQ;
            REQ: begin
                if (i_mem_req_ready) begin
                    state_d = WAIT;
                    kill_d  = jmp_go;
                end
            end
            WAIT: begin
                if (i_mem_rsp_valid) begin
                    kill_d = 1'b0;
                    if (!kill_q && !jmp_go) begin
                        cap     = 1'b1;
                        state_d = HOLD;
                    end else begin
                        state_d = REQ;
                    end
                end else if (jmp_go) begin
                    kill_d = 1'b1;
                end
            end
            HOLD: begin
                if (jmp_go || i_ready) begin
                    state_d = REQ;
                    pc_d    = pc_q + ADDR_WIDTH'(4);
                end
            end
            default: state_d = IDLE;
        endcase
        if (jmp_go) pc_d = jmp_tgt;
    end

    always_comb begin
        o_mem_req_valid = (state_q == REQ);
        o_mem_req_addr  = (state_q == REQ) ? pc_q : '0;
        o_valid         = (state_q == HOLD);
    end

    assign o_pc           = opc_q;
    assign o_inst         = inst_q;
    assign o_exc_misalign = exc_q;

endmodule

// File: tb/tb_ifu.sv
// Randomized bench for ifu against a fetch-stream reference model with a latency-varying memory.
module tb_ifu;
    localparam logic [31:0] RST_PC = 32'h8000_0000;
`ifdef IFU_MISALIGN_CHK_EN
    localparam bit CHK = 1'b1;
`else
    localparam bit CHK = 1'b0;
`endif

    logic        i_clk = 1'b0;
    logic        i_rst_n = 1'b0;
    logic        o_mem_req_valid;
    logic        i_mem_req_ready = 1'b0;
    logic [31:0] o_mem_req_addr;
    logic        i_mem_rsp_valid = 1'b0;
    logic [31:0] i_mem_rsp_data = '0;
    logic        i_jmp_en = 1'b0;
    logic [31:0] i_jmp_pc = '0;
    logic        o_valid;
    logic        i_ready = 1'b0;
    logic [31:0] o_pc;
    logic [31:0] o_inst;
    logic        o_exc_misalign;

    always #5 i_clk = ~i_clk;

    ifu #(.ADDR_WIDTH(32), .INST_WIDTH(32), .RESET_PC(RST_PC)) dut (
        .i_clk(i_clk), .i_rst_n(i_rst_n),
        .o_mem_req_valid(o_mem_req_valid), .i_mem_req_ready(i_mem_req_ready),
        .o_mem_req_addr(o_mem_req_addr), .i_mem_rsp_valid(i_mem_rsp_valid),
        .i_mem_rsp_data(i_mem_rsp_data), .i_jmp_en(i_jmp_en), .i_jmp_pc(i_jmp_pc),
        .o_valid(o_valid), .i_ready(i_ready), .o_pc(o_pc), .o_inst(o_inst),
        .o_exc_misalign(o_exc_misalign)
    );

    int n_chk = 0;
    int n_fail = 0;

    // Reference model: expected fetch-stream pc, presentation state, one pending memory access.
    logic [31:0] exp_pc;
    bit          exp_valid, exp_exc, pend, killed, stray_en;
    logic [31:0] pend_addr;
    int          pend_cnt, lat_next, n_deliv;
    logic [31:0] acc_q[$];

    function automatic logic [31:0] memfn(input logic [31:0] a);
        return {a[15:0], a[31:16]} ^ 32'hC3A5_0F1E;
    endfunction

    task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, act, exp, $time);
        end
    endtask

    task automatic step(input bit rr, input bit ir, input bit jmp, input logic [31:0] jpc);
        bit req, acc, rsp, good, app, mis, v_old;
        logic [31:0] tgt;
        req = !pend && !exp_valid;
        check("req_valid", o_mem_req_valid, req);
        if (o_mem_req_valid) check("req_addr", o_mem_req_addr, exp_pc);
        check("valid", o_valid, exp_valid);
        if (o_valid) begin
            check("pc", o_pc, exp_pc);
            check("inst", o_inst, memfn(exp_pc));
        end
        check("exc", o_exc_misalign, exp_exc);
        rsp = pend && (pend_cnt == 0);
        mis = jmp && (jpc[1:0] != 2'b00);
        app = jmp && !(CHK && mis);
        tgt = CHK ? jpc : {jpc[31:2], 2'b00};
        i_mem_req_ready = rr;
        i_ready         = ir;
        i_jmp_en        = jmp;
        i_jmp_pc        = jpc;
        i_mem_rsp_valid = rsp || (!pend && stray_en && ($urandom_range(0, 3) == 0));
        i_mem_rsp_data  = rsp ? memfn(pend_addr) : $urandom;
        acc  = req && rr;
        good = rsp && !killed && !app;
        v_old = exp_valid;
        @(posedge i_clk);
        if (acc) begin
            acc_q.push_back(exp_pc);
            pend = 1; pend_addr = exp_pc; pend_cnt = lat_next; killed = app;
        end else if (rsp) begin
            pend = 0; killed = 0;
        end else if (pend) begin
            pend_cnt--;
            if (app) killed = 1;
        end
        if (v_old && ir) n_deliv++;
        exp_exc   = CHK && mis;
        exp_valid = good || (v_old && !ir && !app);
        if (app) exp_pc = tgt;
        else if (v_old && ir) exp_pc = exp_pc + 32'd4;
        @(negedge i_clk);
    endtask

    task automatic do_reset();
        i_rst_n = 1'b0;
        i_mem_req_ready = 0; i_ready = 0; i_jmp_en = 0; i_jmp_pc = '0;
        i_mem_rsp_valid = 0;
        @(posedge i_clk);
        @(negedge i_clk);
        check("rst_req_valid", o_mem_req_valid, 0);
        check("rst_req_addr", o_mem_req_addr, 0);
        check("rst_valid", o_valid, 0);
        check("rst_pc", o_pc, 0);
        check("rst_inst", o_inst, 0);
        check("rst_exc", o_exc_misalign, 0);
        exp_pc = RST_PC; exp_valid = 0; exp_exc = 0; pend = 0; killed = 0; pend_cnt = 0;
        // stale response arriving during the first cycle after release
        i_mem_rsp_valid = 1'b1;
        i_mem_rsp_data  = 32'hDEAD_BEEF;
        i_rst_n = 1'b1;
        @(posedge i_clk);
        @(negedge i_clk);
    endtask

    task automatic wait_valid(input string tag);
        bit ok = 0;
        for (int i = 0; i < 40 && !ok; i++) begin
            if (o_valid) ok = 1;
            else step(1, 0, 0, '0);
        end
        check(tag, ok, 1);
    endtask

    task automatic wait_pend(input string tag);
        bit ok = 0;
        for (int i = 0; i < 40 && !ok; i++) begin
            if (pend) ok = 1;
            else step(1, 1, 0, '0);
        end
        check(tag, ok, 1);
    endtask

    initial begin
        logic [31:0] pc0, inst0, exp_m;
        int na;
        bit rr, ir, jmp;
        logic [31:0] jpc;
        stray_en = 0; lat_next = 0; n_deliv = 0;
        @(negedge i_clk);
        do_reset();

        // sequential fetch, latency 1, decode always ready
        acc_q.delete();
        for (int i = 0; i < 9; i++) step(1, 1, 0, '0);
        check("seq_n", acc_q.size() >= 3, 1);
        if (acc_q.size() >= 3) begin
            check("seq_a0", acc_q[0], 32'h8000_0000);
            check("seq_a1", acc_q[1], 32'h8000_0004);
            check("seq_a2", acc_q[2], 32'h8000_0008);
        end

        // decode stalls in HOLD
        wait_valid("wait_hold");
        pc0 = o_pc; inst0 = o_inst; na = acc_q.size();
        for (int i = 0; i < 5; i++) step(1, 0, 0, '0);
        check("hold_valid", o_valid, 1);
        check("hold_pc", o_pc, pc0);
        check("hold_inst", o_inst, inst0);
        check("hold_noreq", acc_q.size(), na);
        step(1, 1, 0, '0);

        // redirect while waiting on a slow response
        lat_next = 3;
        wait_pend("wait_pend1");
        step(1, 1, 1, 32'h8000_0100);
        lat_next = 0;
        wait_valid("wait_redir1");
        check("redir_wait_pc", o_pc, 32'h8000_0100);

        // redirect coincident with consume in HOLD
        step(1, 1, 1, 32'h8000_0040);
        wait_valid("wait_redir2");
        check("redir_hold_pc", o_pc, 32'h8000_0040);

        // reset while waiting, stale response afterwards
        lat_next = 3;
        wait_pend("wait_pend2");
        step(1, 1, 0, '0);
        do_reset();
        acc_q.delete();
        lat_next = 0;
        step(1, 1, 0, '0);
        check("rst_acc_n", acc_q.size(), 1);
        if (acc_q.size() > 0) check("rst_first_addr", acc_q[0], RST_PC);

        // misaligned redirect
        wait_valid("wait_mis");
        pc0 = exp_pc;
        step(1, 1, 1, 32'h8000_0002);
        check("mis_exc", o_exc_misalign, CHK);
        step(1, 1, 0, '0);
        check("mis_exc_clr", o_exc_misalign, 0);
`ifdef IFU_MISALIGN_CHK_EN
        exp_m = pc0 + 32'd4;
`else
        exp_m = 32'h8000_0000;
`endif
        wait_valid("wait_mis2");
        check("mis_pc", o_pc, exp_m);

        // randomized traffic, including pc wraparound targets
        stray_en = 1;
        for (int i = 0; i < 4000; i++) begin
            lat_next = $urandom_range(0, 3);
            rr  = ($urandom_range(0, 3) != 0);
            ir  = ($urandom_range(0, 1) != 0);
            jmp = ($urandom_range(0, 11) == 0);
            if ($urandom_range(0, 7) == 0) jpc = 32'hFFFF_FFF8 | ($urandom & 32'h3);
            else jpc = 32'h8000_0000 | ($urandom & 32'h0000_0FFF);
            if (i == 2000) do_reset();
            step(rr, ir, jmp, jpc);
        end
        check("deliv_min", n_deliv >= 100, 1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule

// File: doc/ifu.md
Name: ifu

Overview:
- Instruction fetch unit for the L1 core; it is the upstream end of the decode-stage handshake.
- Holds the architectural PC and issues one word fetch at a time to instruction memory over a req/rsp handshake.
- Presents {pc, inst} to the decode stage with o_valid/i_ready.
- Accepts redirects from the jump/branch resolution path and discards stale in-flight responses.

Parameters:
ADDR_WIDTH, 32, PC and memory address width.
INST_WIDTH, 32, instruction width.
RESET_PC, 32'h8000_0000, PC value loaded on reset.

Ports:
i_clk  input  1  clock, rising edge.
i_rst_n  input  1  asynchronous active-low reset.
o_mem_req_valid  output  1  fetch request valid.
i_mem_req_ready  input  1  memory accepts request.
o_mem_req_addr  output  ADDR_WIDTH  fetch address (word aligned).
i_mem_rsp_valid  input  1  fetch response valid (one per accepted request, in order).
i_mem_rsp_data  input  INST_WIDTH  fetched instruction.
i_jmp_en  input  1  redirect request, single-cycle pulse.
i_jmp_pc  input  ADDR_WIDTH  redirect target.
o_valid  output  1  instruction available to decode.
i_ready  input  1  decode accepts instruction.
o_pc  output  ADDR_WIDTH  PC of presented instruction.
o_inst  output  INST_WIDTH  presented instruction.
o_exc_misalign  output  1  misaligned redirect flag (see Optional Feature).

Behaviour:
- Reset (async assert, sync-safe deassert): pc=RESET_PC, state=IDLE, kill=0, o_mem_req_valid=0, o_mem_req_addr=0, o_valid=0, o_pc=0, o_inst=0, o_exc_misalign=0.
- IDLE -> REQ on the first clock after reset release. o_mem_req_valid=0.
- REQ: o_mem_req_valid=1, o_mem_req_addr=pc. On i_mem_req_ready -> WAIT.
- WAIT: o_mem_req_valid=0. On i_mem_rsp_valid:
  - kill=1: drop the response, clear kill, -> REQ.
  - otherwise: register o_inst=rsp_data and o_pc=pc, set o_valid=1, -> HOLD.
- HOLD: o_valid=1. o_pc/o_inst are held stable while !i_ready. On i_ready: o_valid=0, pc=pc+4, -> REQ.
- Fetch latency: the request is accepted in cycle N, the response arrives in cycle N+k (k>=1), and o_valid rises in cycle N+k+1. Throughput is at most 1 instruction per 3 cycles; this is acceptable for this version.
- PC arithmetic: pc+4 is modulo 2^ADDR_WIDTH, so 0xFFFF_FFFC wraps to 0x0000_0000.
- Redirect (i_jmp_en=1) has priority over sequential update in every state:
  - IDLE: pc=i_jmp_pc, -> REQ.
  - REQ without acceptance: pc=i_jmp_pc, stay REQ. The next cycle's address is the new target; the memory must tolerate withdrawal or change of an unaccepted request.
  - REQ with i_mem_req_ready the same cycle: the request with the old address is accepted, kill=1, pc=i_jmp_pc, -> WAIT.
  - WAIT without rsp: kill=1, pc=i_jmp_pc.
  - WAIT with rsp the same cycle: the response is dropped, kill=0, pc=i_jmp_pc, -> REQ.
  - HOLD: o_valid=0 the next cycle, pc=i_jmp_pc, -> REQ. If i_ready is also high, the instruction counts as consumed, but the target is i_jmp_pc, not pc+4.
- i_mem_rsp_valid outside WAIT is ignored. This covers a stale response arriving after reset.
- At most one outstanding request at any time.

Optional Feature:
- Macro: IFU_MISALIGN_CHK_EN.
- Defined:
  - An i_jmp_en with i_jmp_pc[1:0]!=0 is not applied; pc and state are unchanged.
  - o_exc_misalign is registered high for exactly one cycle, in the cycle after the offending i_jmp_en.
  - Aligned redirects behave as above.
- Undefined:
  - o_exc_misalign is tied 0.
  - i_jmp_pc[1:0] is forced to 2'b00 before the redirect is applied.

Test Plan:
- Reset, memory ready=1, rsp latency 1, i_ready=1 -> fetch addrs 0x8000_0000, 0x8000_0004, 0x8000_0008 in order; each o_valid carries the matching o_pc and the memory word.
- Hold i_ready=0 for 5 cycles in HOLD -> o_valid stays 1, and o_pc/o_inst are unchanged; no new o_mem_req_valid until i_ready.
- i_jmp_en with target 0x8000_0100 while in WAIT, response 0xDEAD_BEEF arrives 3 cycles later -> response dropped, next request address 0x8000_0100, o_valid never shows 0xDEAD_BEEF.
- i_jmp_en coincident with the i_ready handshake in HOLD, target 0x8000_0040 -> next request 0x8000_0040, not pc+4.
- Assert i_rst_n low while in WAIT, then release, then deliver a stale rsp -> outputs zero during reset; the stale rsp is ignored; the first request is 0x8000_0000.
- With IFU_MISALIGN_CHK_EN, redirect to 0x8000_0002 -> o_exc_misalign=1 for one cycle and the fetch stream continues sequentially. Without the macro, the same redirect fetches 0x8000_0000.
